// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - unified memory port arbiter between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_D_RUN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [2:0]      d_size,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  input  logic            hlt,
  output logic            halted,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int RW = $clog2(MAX_D_RUN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_D,
    S_ERR,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     run_q, run_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic              d_illegal;
  logic [NB-1:0]     d_be;
  logic [XLEN-1:0]   d_wdata_rep;
  logic [XLEN-1:0]   rd_shift_b;
  logic [XLEN-1:0]   rd_shift_h;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   load_ext;
  logic              force_if;
  logic              d_grant;
  logic              unused_if_addr_bits;

  // Fetches are always whole words, so the low fetch address bits carry no information.
  assign unused_if_addr_bits = ^if_addr[1:0];

  // Decode the load/store size into byte enables, replicated write data and legality.
  always_comb begin
    d_illegal   = 1'b0;
    d_be        = '0;
    d_wdata_rep = d_wdata;
    case (d_size)
      3'b000, 3'b100: begin
        d_be        = NB'(1) << d_addr[1:0];
        d_wdata_rep = {NB{d_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        d_illegal   = d_addr[0];
        d_be        = NB'(3) << {d_addr[1], 1'b0};
        d_wdata_rep = {(NB/2){d_wdata[15:0]}};
      end
      3'b010: begin
        d_illegal   = |d_addr[1:0];
        d_be        = '1;
      end
      default: d_illegal = 1'b1;
    endcase
    // Unsigned sizes only make sense for loads.
    if (d_size[2] && d_we) begin
      d_illegal = 1'b1;
    end
  end

  // Pick the addressed lane out of the returned word and extend it per the captured size.
  always_comb begin
    rd_shift_b = mem_rdata >> {lane_q, 3'b000};
    rd_shift_h = mem_rdata >> {lane_q[1], 4'b0000};
    ld_byte    = rd_shift_b[7:0];
    ld_half    = rd_shift_h[15:0];
    case (size_q)
      3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Data wins over fetch unless fetch has waited through MAX_D_RUN data grants in a row.
  assign force_if = if_req && (run_q == RW'(MAX_D_RUN));
  assign d_grant  = d_req && !force_if;

  // Arbitration FSM: next state, run counter and registered memory/response outputs.
  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    lane_d      = lane_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;

    // No pending fetch means nobody is being starved.
    if (!if_req) begin
      run_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (hlt) begin
          state_d = S_HALTED;
        end else if (d_grant) begin
          if (if_req && (run_q != RW'(MAX_D_RUN))) begin
            run_d = run_q + RW'(1);
          end
          if (d_illegal) begin
            state_d   = S_ERR;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d     = S_BUSY_D;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = {d_addr[XLEN-1:2], 2'b00};
            mem_be_d    = d_be;
            mem_wdata_d = d_wdata_rep;
            size_d      = d_size;
            lane_d      = d_addr[1:0];
          end
        end else if (if_req) begin
          state_d     = S_BUSY_IF;
          run_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[XLEN-1:2], 2'b00};
          mem_be_d    = '1;
          mem_wdata_d = '0;
        end
      end
      S_BUSY_IF: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = S_IDLE;
        end
      end
      S_BUSY_D: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          d_rdata_d = mem_we_q ? '0 : load_ext;
          state_d   = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      size_q      <= '0;
      lane_q      <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign halted    = (state_q == S_HALTED);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        hlt;
  logic        halted;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_errors;
  int ready_delay;
  int rcnt;

  mem_port_arbiter #(.XLEN(32), .MAX_D_RUN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .hlt       (hlt),
    .halted    (halted),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: raise mem_ready after ready_delay cycles of mem_req.
  initial begin
    mem_ready = 1'b0;
    rcnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ready = (rcnt >= ready_delay);
        rcnt++;
      end else begin
        mem_ready = 1'b0;
        rcnt      = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic d_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic saw,
                          output logic [31:0] a, output logic [3:0] be, output logic w,
                          output logic [31:0] wd, output logic [31:0] rd, output logic er);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    lat = 0; saw = 1'b0; a = '0; be = '0; w = 1'b0; wd = '0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_req && !saw) begin
        saw = 1'b1; a = mem_addr; be = mem_be; w = mem_we; wd = mem_wdata;
      end
      if (d_valid) begin
        lat = i; rd = d_rdata; er = d_err;
        break;
      end
    end
    d_req = 1'b0;
  endtask

  int          lat;
  logic        saw;
  logic [31:0] ca;
  logic [3:0]  cbe;
  logic        cw;
  logic [31:0] cwd;
  logic [31:0] crd;
  logic        cer;
  int          ngrant;
  logic        prev_req;
  logic        seen;
  int          busy_cnt;

  initial begin
    n_checks = 0; n_errors = 0; ready_delay = 0;
    rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; hlt = 0; mem_rdata = 0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_valids", {28'd0, if_valid, d_valid, d_err, halted}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // IF only, aligned down, ready on first mem_req cycle
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h103;
    lat = 0; saw = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_req && !saw) begin
        saw = 1'b1;
        check("if_mem_addr", mem_addr, 32'h100);
        check("if_mem_be", 32'(mem_be), 32'hF);
        check("if_mem_we", 32'(mem_we), 32'd0);
      end
      if (if_valid) begin
        lat = i;
        check("if_rdata", if_rdata, 32'hDEADBEEF);
        break;
      end
    end
    if_req = 1'b0;
    check("if_latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("if_valid_pulse", 32'(if_valid), 32'd0);

    // LB / LBU lane 3
    mem_rdata = 32'h80AABBCC;
    d_access(1'b0, 3'b000, 32'h2003, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("lb_latency", 32'(lat), 32'd2);
    check("lb_addr", ca, 32'h2000);
    check("lb_be", 32'(cbe), 32'h8);
    check("lb_rdata", crd, 32'hFFFFFF80);
    check("lb_err", 32'(cer), 32'd0);
    d_access(1'b0, 3'b100, 32'h2003, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("lbu_rdata", crd, 32'h00000080);
    @(negedge clk);
    check("d_valid_pulse", 32'(d_valid), 32'd0);

    // LH / LHU upper half
    d_access(1'b0, 3'b001, 32'h2002, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("lh_be", 32'(cbe), 32'hC);
    check("lh_rdata", crd, 32'hFFFF80AA);
    d_access(1'b0, 3'b101, 32'h2002, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("lhu_rdata", crd, 32'h000080AA);
    d_access(1'b0, 3'b000, 32'h2000, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("lb0_rdata", crd, 32'hFFFFFFCC);

    // SH upper half, SB lane 1
    d_access(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("sh_we", 32'(cw), 32'd1);
    check("sh_be", 32'(cbe), 32'hC);
    check("sh_wdata", cwd, 32'hABCDABCD);
    check("sh_rdata", crd, 32'd0);
    check("sh_latency", 32'(lat), 32'd2);
    d_access(1'b1, 3'b000, 32'h2001, 32'h0000005A, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("sb_be", 32'(cbe), 32'h2);
    check("sb_wdata", cwd, 32'h5A5A5A5A);

    // Misaligned / illegal: no memory access, error one cycle later
    d_access(1'b0, 3'b010, 32'h2001, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("lw_mis_req", 32'(saw), 32'd0);
    check("lw_mis_err", 32'(cer), 32'd1);
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_rdata", crd, 32'd0);
    d_access(1'b1, 3'b001, 32'h1, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("sh_mis_req", 32'(saw), 32'd0);
    check("sh_mis_err", 32'(cer), 32'd1);
    d_access(1'b1, 3'b100, 32'h0, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("sbu_illegal_err", 32'(cer), 32'd1);
    d_access(1'b0, 3'b011, 32'h0, 32'h0, lat, saw, ca, cbe, cw, cwd, crd, cer);
    check("size011_err", 32'(cer), 32'd1);
    @(negedge clk);
    check("d_err_pulse", 32'(d_err), 32'd0);

    // Both requesters held: D,D,D,D,IF repeating
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h800;
    ngrant = 0; prev_req = 1'b0;
    for (int i = 0; i < 100 && ngrant < 10; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        check($sformatf("grant%0d", ngrant), mem_addr,
              (ngrant % 5 == 4) ? 32'h400 : 32'h800);
        ngrant++;
      end
      prev_req = mem_req;
    end
    check("grant_count", 32'(ngrant), 32'd10);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);

    // hlt mid BUSY_D with delayed ready
    ready_delay = 3; mem_rdata = 32'h11223344;
    d_req = 1'b1; d_we = 1'b0; d_size = 3'b010; d_addr = 32'h3000;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    check("halt_req_seen", 32'(seen), 32'd1);
    hlt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_valid) begin
        seen = 1'b1;
        check("halt_d_rdata", d_rdata, 32'h11223344);
        break;
      end
    end
    check("halt_d_valid", 32'(seen), 32'd1);
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    repeat (2) @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req || if_valid) busy_cnt++;
    end
    check("halted_no_grant", 32'(busy_cnt), 32'd0);

    // Reset releases halt; reset mid-access clears outputs at once
    rst_n = 1'b0; hlt = 1'b0; if_req = 1'b0;
    #1;
    check("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_delay = 5;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h600;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    check("rst_mid_req_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_mem_be", 32'(mem_be), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_valid || mem_req) busy_cnt++;
    end
    check("rst_mid_no_valid", 32'(busy_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
